// File: rtl/uart_pkg.sv
// Shared UART definitions: line states, framing constants, idle level.
// Used by the console transmitter and the future console receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int   UART_DATA_BITS  = 8;
  localparam int   UART_STOP_BITS  = 1;
  localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty and a separate occupancy count.
// Pointers wrap modulo DEPTH; count runs 0..DEPTH inclusive.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             full_q;
  logic             empty_q;
  logic             push_ok;
  logic             pop_ok;

  // A write while full is dropped even if a pop frees a slot this cycle.
  assign push_ok = push_i && !full_q;
  assign pop_ok  = pop_i && !empty_q;

  always_comb begin
    count_d = count_q;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      full_q  <= (count_d == CW'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign count_o = count_q;

endmodule

// File: rtl/uart_console_tx.sv
// Console UART transmitter: write FIFO feeding an 8N1 LSB-first serialiser.
// Frames are sent back-to-back while the FIFO has data.
import uart_pkg::*;

module uart_console_tx #(
  parameter int CLKS_PER_BIT = 200,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [7:0]                    wr_data,
  output logic                          full,
  output logic                          empty,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          tx
);

  localparam int BW = $clog2(CLKS_PER_BIT);

  uart_state_e state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          pop;
  logic          bit_end;
  logic          fifo_empty;
  logic [7:0]    fifo_data;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (wr_en),
    .data_i  (wr_data),
    .pop_i   (pop),
    .data_o  (fifo_data),
    .full_o  (full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign bit_end = (baud_q == BW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= UART_IDLE_LEVEL;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + BW'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        baud_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_data;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          baud_d  = '0;
          idx_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'(UART_DATA_BITS - 1)) state_d = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_d  = '0;
          state_d = IDLE;
          // Chain straight into the next start bit when more data waits.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_data;
            state_d = START;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level is computed from next state so tx stays a plain flop.
  always_comb begin
    tx_d   = UART_IDLE_LEVEL;
    busy_d = (state_d != IDLE);
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = UART_IDLE_LEVEL;
    endcase
  end

  assign tx    = tx_q;
  assign busy  = busy_q;
  assign empty = fifo_empty;

endmodule

// File: tb/tb_uart_console_tx.sv
// Bench for uart_console_tx: cycle-exact line checks plus a frame decoder
// whose received bytes are compared with the bytes the bench pushed.
module tb_uart_console_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 16;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       full;
  logic       empty;
  logic       busy;
  logic [4:0] fifo_count;
  logic       tx;

  int vectors = 0;
  int miscompares = 0;

  uart_console_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .full       (full),
    .empty      (empty),
    .busy       (busy),
    .fifo_count (fifo_count),
    .tx         (tx)
  );

  always #5 clk = ~clk;

  // Line level expected in bit slot i of an 8N1 frame carrying b.
  function automatic logic fbit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    if (i == 9) return 1'b1;
    return b[i-1];
  endfunction

  // Independent line decoder: samples each bit slot in its middle.
  logic [7:0] rx_q[$];
  logic [7:0] dq;
  int         pos;
  int         kb;
  bit         inf = 1'b0;
  int         frame_err = 0;

  always @(negedge clk) begin
    if (rst) begin
      inf = 1'b0;
    end else begin
      if (!inf && tx === 1'b0) begin
        inf = 1'b1;
        pos = 0;
      end else if (inf) begin
        pos++;
      end
      if (inf) begin
        if (pos % CPB == CPB / 2) begin
          kb = pos / CPB;
          if (kb == 0 && tx !== 1'b0) frame_err++;
          else if (kb >= 1 && kb <= 8) dq[kb-1] = tx;
          else if (kb == 9 && tx !== 1'b1) frame_err++;
        end
        if (pos == FRAME - 1) begin
          rx_q.push_back(dq);
          inf = 1'b0;
        end
      end
    end
  end

  task automatic test_reset;
    repeat (2) @(negedge clk);
    vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL rst_tx: got %b want 1", tx); end
    vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL rst_full: got %b want 0", full); end
    vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL rst_empty: got %b want 1", empty); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b want 0", busy); end
    vectors++; if (fifo_count !== 5'd0) begin miscompares++; $display("FAIL rst_count: got %0d want 0", fifo_count); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (tx !== 1'b1 || busy !== 1'b0 || empty !== 1'b1) begin
      miscompares++; $display("FAIL post_rst_idle: got tx=%b busy=%b empty=%b want 1 0 1", tx, busy, empty);
    end
  endtask

  task automatic test_single_byte;
    logic [7:0] b;
    b = 8'h55;
    rx_q.delete();
    @(negedge clk); wr_en = 1'b1; wr_data = b;
    @(negedge clk); wr_en = 1'b0;
    vectors++; if (empty !== 1'b0) begin miscompares++; $display("FAIL single_empty_after_push: got %b want 0", empty); end
    vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL single_tx_before_pop: got %b want 1", tx); end
    vectors++; if (fifo_count !== 5'd1) begin miscompares++; $display("FAIL single_count: got %0d want 1", fifo_count); end
    @(negedge clk);
    vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL single_empty_after_pop: got %b want 1", empty); end
    for (int k = 0; k < FRAME; k++) begin
      if (k > 0) @(negedge clk);
      vectors++; if (tx !== fbit(b, k / CPB)) begin
        miscompares++; $display("FAIL single_line c%0d: got %b want %b", k, tx, fbit(b, k / CPB));
      end
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL single_busy c%0d: got %b want 1", k, busy); end
    end
    @(negedge clk);
    vectors++; if (tx !== 1'b1 || busy !== 1'b0) begin
      miscompares++; $display("FAIL single_end: got tx=%b busy=%b want 1 0", tx, busy);
    end
    vectors++; if (rx_q.size() != 1 || rx_q[0] !== b) begin
      miscompares++; $display("FAIL single_decode: got n=%0d want 1 byte %h", rx_q.size(), b);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] b;
    @(negedge clk); wr_en = 1'b1; wr_data = 8'h00;
    @(negedge clk); wr_data = 8'hFF;
    @(negedge clk); wr_en = 1'b0;
    vectors++; if (fifo_count !== 5'd1) begin miscompares++; $display("FAIL b2b_push_pop_count: got %0d want 1", fifo_count); end
    for (int k = 0; k < 2 * FRAME; k++) begin
      if (k > 0) @(negedge clk);
      b = (k < FRAME) ? 8'h00 : 8'hFF;
      vectors++; if (tx !== fbit(b, (k % FRAME) / CPB) || busy !== 1'b1) begin
        miscompares++; $display("FAIL b2b_line c%0d: got tx=%b busy=%b want %b 1", k, tx, busy, fbit(b, (k % FRAME) / CPB));
      end
      if (k == FRAME) begin
        vectors++; if (fifo_count !== 5'd0) begin miscompares++; $display("FAIL b2b_count2: got %0d want 0", fifo_count); end
      end
    end
    @(negedge clk);
    vectors++; if (tx !== 1'b1 || busy !== 1'b0 || empty !== 1'b1) begin
      miscompares++; $display("FAIL b2b_end: got tx=%b busy=%b empty=%b want 1 0 1", tx, busy, empty);
    end
  endtask

  task automatic test_overflow;
    rx_q.delete();
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if (i == 16) begin
        vectors++; if (full !== 1'b0 || fifo_count !== 5'd15) begin
          miscompares++; $display("FAIL ovf_16th: got full=%b count=%0d want 0 15", full, fifo_count);
        end
      end
      if (i == 17) begin
        vectors++; if (full !== 1'b1 || fifo_count !== 5'd16) begin
          miscompares++; $display("FAIL ovf_17th: got full=%b count=%0d want 1 16", full, fifo_count);
        end
      end
      wr_en = 1'b1; wr_data = 8'hA0 + 8'(i);
    end
    @(negedge clk); wr_en = 1'b0;
    vectors++; if (full !== 1'b1 || fifo_count !== 5'd16) begin
      miscompares++; $display("FAIL ovf_drop: got full=%b count=%0d want 1 16", full, fifo_count);
    end
    for (int t = 0; t < 17 * FRAME + 60 && rx_q.size() < 17; t++) @(negedge clk);
    repeat (2 * FRAME) @(negedge clk);
    vectors++; if (rx_q.size() != 17) begin miscompares++; $display("FAIL ovf_frames: got %0d want 17", rx_q.size()); end
    for (int i = 0; i < 17 && i < rx_q.size(); i++) begin
      vectors++; if (rx_q[i] !== 8'hA0 + 8'(i)) begin
        miscompares++; $display("FAIL ovf_byte%0d: got %h want %h", i, rx_q[i], 8'hA0 + 8'(i));
      end
    end
    vectors++; if (empty !== 1'b1 || busy !== 1'b0) begin
      miscompares++; $display("FAIL ovf_drained: got empty=%b busy=%b want 1 0", empty, busy);
    end
  endtask

  task automatic test_push_while_full_pop;
    logic [7:0] exp[17];
    rx_q.delete();
    for (int i = 0; i < 17; i++) exp[i] = 8'($urandom);
    for (int i = 0; i < 17; i++) begin
      @(negedge clk); wr_en = 1'b1; wr_data = exp[i];
    end
    @(negedge clk); wr_en = 1'b0;
    // Now after push edge 17; the first pop happened at edge 2, next at 42.
    repeat (24) @(negedge clk);
    vectors++; if (full !== 1'b1 || fifo_count !== 5'd16) begin
      miscompares++; $display("FAIL pwf_before: got full=%b count=%0d want 1 16", full, fifo_count);
    end
    wr_en = 1'b1; wr_data = 8'h3C;
    @(negedge clk); wr_en = 1'b0;
    vectors++; if (full !== 1'b0 || fifo_count !== 5'd15) begin
      miscompares++; $display("FAIL pwf_after: got full=%b count=%0d want 0 15", full, fifo_count);
    end
    vectors++; if (tx !== 1'b0) begin miscompares++; $display("FAIL pwf_next_start: got %b want 0", tx); end
    for (int t = 0; t < 17 * FRAME + 60 && rx_q.size() < 17; t++) @(negedge clk);
    repeat (2 * FRAME) @(negedge clk);
    vectors++; if (rx_q.size() != 17) begin miscompares++; $display("FAIL pwf_frames: got %0d want 17", rx_q.size()); end
    for (int i = 0; i < 17 && i < rx_q.size(); i++) begin
      vectors++; if (rx_q[i] !== exp[i]) begin
        miscompares++; $display("FAIL pwf_byte%0d: got %h want %h", i, rx_q[i], exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    int bad;
    rx_q.delete();
    @(negedge clk); wr_en = 1'b1; wr_data = 8'h81;
    @(negedge clk); wr_data = 8'h42;
    @(negedge clk); wr_en = 1'b0;
    repeat (17) @(negedge clk);
    vectors++; if (tx !== 1'b0 || busy !== 1'b1 || fifo_count !== 5'd1) begin
      miscompares++; $display("FAIL mid_pre: got tx=%b busy=%b count=%0d want 0 1 1", tx, busy, fifo_count);
    end
    #2 rst = 1'b1;
    #1;
    vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL mid_async_tx: got %b want 1", tx); end
    vectors++; if (busy !== 1'b0 || fifo_count !== 5'd0 || empty !== 1'b1 || full !== 1'b0) begin
      miscompares++; $display("FAIL mid_async_state: got busy=%b count=%0d empty=%b full=%b want 0 0 1 0", busy, fifo_count, empty, full);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int t = 0; t < 3 * FRAME; t++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    vectors++; if (bad != 0) begin miscompares++; $display("FAIL mid_no_resume: got %0d active cycles want 0", bad); end
    vectors++; if (rx_q.size() != 0) begin miscompares++; $display("FAIL mid_no_frames: got %0d want 0", rx_q.size()); end
  endtask

  task automatic test_wrap_around;
    rx_q.delete();
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 10; i++) begin
        @(negedge clk); wr_en = 1'b1; wr_data = 8'(b * 10 + i);
      end
      @(negedge clk); wr_en = 1'b0;
      vectors++; if (fifo_count !== 5'd9) begin
        miscompares++; $display("FAIL wrap_count b%0d: got %0d want 9", b, fifo_count);
      end
      for (int t = 0; t < 10 * FRAME + 60 && rx_q.size() < (b + 1) * 10; t++) @(negedge clk);
      repeat (5) @(negedge clk);
    end
    vectors++; if (rx_q.size() != 40) begin miscompares++; $display("FAIL wrap_frames: got %0d want 40", rx_q.size()); end
    for (int i = 0; i < 40 && i < rx_q.size(); i++) begin
      vectors++; if (rx_q[i] !== 8'(i)) begin
        miscompares++; $display("FAIL wrap_byte%0d: got %h want %h", i, rx_q[i], 8'(i));
      end
    end
  endtask

  task automatic test_random;
    logic [7:0] exp_q[$];
    int n;
    rx_q.delete();
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) begin
        @(negedge clk); wr_en = 1'b1; wr_data = 8'($urandom);
        exp_q.push_back(wr_data);
        if ($urandom_range(0, 2) == 0) begin
          @(negedge clk); wr_en = 1'b0;
        end
      end
      @(negedge clk); wr_en = 1'b0;
      for (int t = 0; t < DEPTH * FRAME + 60 && rx_q.size() < exp_q.size(); t++) @(negedge clk);
      repeat (5) @(negedge clk);
    end
    vectors++; if (rx_q.size() != exp_q.size()) begin
      miscompares++; $display("FAIL rand_frames: got %0d want %0d", rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      vectors++; if (rx_q[i] !== exp_q[i]) begin
        miscompares++; $display("FAIL rand_byte%0d: got %h want %h", i, rx_q[i], exp_q[i]);
      end
    end
    vectors++; if (frame_err != 0) begin miscompares++; $display("FAIL framing: got %0d errors want 0", frame_err); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_overflow();
    test_push_while_full_pop();
    test_reset_mid_frame();
    test_wrap_around();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
